// File: rtl/uart_mmio_if.sv
// Bus leg between the system decoder/read mux and the UART slave.
interface uart_mmio_if;
  logic [3:0]  addr;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output wen, output wdata, input rdata);
  modport slave  (input addr, input wen, input wdata, output rdata);
endinterface

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART slave, single-byte TX, optional RX.
// Optional receiver is compiled in only when UART_RX_EN is defined.
//
// state    | meaning
// TX_IDLE  | line high, waiting for a TXDATA write
// TX_START | driving the start bit (low)
// TX_DATA  | shifting 8 data bits, LSB first
// TX_STOP  | driving the stop bit (high)
// RX_IDLE  | waiting for a synchronised 1->0 edge
// RX_START | half-bit wait, then confirm start bit still low
// RX_DATA  | sampling 8 data bits mid-bit, LSB first
// RX_STOP  | sampling the stop bit, then delivering the byte
module uart_mmio #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  uart_mmio_if.slave  bus,
  output logic        uart_txd,
  input  logic        uart_rxd
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          tx_busy, tx_tc, tx_wr, st_wr;
  logic          rx_valid, rx_overrun, rx_frame_err;
  logic [7:0]    rx_data;
  logic          unused_bits;

  assign tx_busy     = (tx_state != TX_IDLE);
  assign tx_tc       = (tx_cnt == '0);
  assign tx_wr       = bus.wen && (bus.addr[3:2] == 2'd0);
  assign st_wr       = bus.wen && (bus.addr[3:2] == 2'd1);
  assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:8]};

  // TX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_state_n;
  end

  // TX next state and serial line; line is decoded from state so reset forces it high at once
  always_comb begin
    tx_state_n = tx_state;
    uart_txd   = 1'b1;
    case (tx_state)
      TX_IDLE:  if (tx_wr) tx_state_n = TX_START;
      TX_START: begin
        uart_txd = 1'b0;
        if (tx_tc) tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        uart_txd = tx_shift[0];
        if (tx_tc && (tx_idx == 3'd7)) tx_state_n = TX_STOP;
      end
      TX_STOP:  if (tx_tc) tx_state_n = TX_IDLE;
      default:  tx_state_n = TX_IDLE;
    endcase
  end

  // TX bit-period down-counter, bit index and shift register; busy writes leave them alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else if (tx_state == TX_IDLE) begin
      if (tx_wr) begin
        tx_cnt   <= BIT_LOAD;
        tx_idx   <= '0;
        tx_shift <= bus.wdata[7:0];
      end
    end else if (tx_tc) begin
      tx_cnt <= BIT_LOAD;
      if (tx_state == TX_DATA) begin
        tx_idx   <= tx_idx + 3'd1;
        tx_shift <= {1'b0, tx_shift[7:1]};
      end
    end else begin
      tx_cnt <= tx_cnt - CW'(1);
    end
  end

`ifdef UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     rx_state, rx_state_n;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_tc, rx_done;

  assign rx_tc   = (rx_cnt == '0);
  assign rx_done = (rx_state == RX_STOP) && rx_tc;

  // Two-flop synchroniser plus one delay flop for falling-edge detection; idle-high reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_n;
  end

  // RX next state; a start bit that is high again at mid-bit is treated as a glitch
  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_state_n = RX_START;
      RX_START: if (rx_tc) rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tc && (rx_idx == 3'd7)) rx_state_n = RX_STOP;
      RX_STOP:  if (rx_tc) rx_state_n = RX_IDLE;
      default:  rx_state_n = RX_IDLE;
    endcase
  end

  // RX counter preloads a half bit while idle so the first sample lands mid start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else if (rx_state == RX_IDLE) begin
      rx_cnt <= HALF_LOAD;
      rx_idx <= '0;
    end else if (rx_tc) begin
      rx_cnt <= BIT_LOAD;
      if (rx_state == RX_DATA) begin
        rx_idx   <= rx_idx + 3'd1;
        rx_shift <= {rx_sync, rx_shift[7:1]};
      end
    end else begin
      rx_cnt <= rx_cnt - CW'(1);
    end
  end

  // Status flags: write-1-to-clear, with a same-cycle hardware set taking priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_data      <= '0;
    end else begin
      rx_valid     <= (rx_valid     & ~(st_wr & bus.wdata[1])) | rx_done;
      rx_overrun   <= (rx_overrun   & ~(st_wr & bus.wdata[2])) | (rx_done & rx_valid);
      rx_frame_err <= (rx_frame_err & ~(st_wr & bus.wdata[3])) | (rx_done & ~rx_sync);
      if (rx_done) rx_data <= rx_shift;
    end
  end
`else
  logic unused_rx;

  assign rx_valid     = 1'b0;
  assign rx_overrun   = 1'b0;
  assign rx_frame_err = 1'b0;
  assign rx_data      = '0;
  assign unused_rx    = ^{uart_rxd, st_wr};
`endif

  // Zero-latency read mux
  always_comb begin
    bus.rdata = '0;
    case (bus.addr[3:2])
      2'd1:    bus.rdata[3:0] = {rx_frame_err, rx_overrun, rx_valid, tx_busy};
      2'd2:    bus.rdata[7:0] = rx_data;
      2'd3:    bus.rdata      = 32'(DIV);
      default: bus.rdata      = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: frame-level model of the TX line and
// register map, per-cycle compare process, plus literal pin checks.
module tb_uart_mmio;
  localparam int CLK_FREQ = 80;
  localparam int BAUD     = 10;
  localparam int DIV      = CLK_FREQ / BAUD;

`ifdef UART_RX_EN
  localparam logic [31:0] EXP_OVR_ST = 32'h6;
  localparam logic [31:0] EXP_RX81   = 32'h81;
  localparam logic [31:0] EXP_FE_ST  = 32'hA;
  localparam logic [31:0] EXP_RX33   = 32'h33;
`else
  localparam logic [31:0] EXP_OVR_ST = 32'h0;
  localparam logic [31:0] EXP_RX81   = 32'h0;
  localparam logic [31:0] EXP_FE_ST  = 32'h0;
  localparam logic [31:0] EXP_RX33   = 32'h0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic uart_txd;
  logic uart_rxd;

  uart_mmio_if bus_if ();

  uart_mmio #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if),
    .uart_txd (uart_txd),
    .uart_rxd (uart_rxd)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // model state
  int         cyc      = 0;
  logic       m_active = 1'b0;
  int         m_start  = 0;
  logic [7:0] m_byte   = '0;
  logic       m_valid  = 1'b0;
  logic       m_over   = 1'b0;
  logic       m_ferr   = 1'b0;
  logic [7:0] m_data   = '0;
  logic       v, o, f;
  int         rx_req   = 0;
  int         rx_ack   = 0;
  logic [7:0] rx_req_byte = '0;
  logic       rx_req_stop = 1'b1;
  logic       rx_quiet = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic busy_at(int c);
    return m_active && (c >= m_start) && (c < m_start + 10 * DIV);
  endfunction

  function automatic logic exp_txd(int c);
    int idx;
    if (!busy_at(c)) return 1'b1;
    idx = (c - m_start) / DIV;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_byte[idx-1];
  endfunction

  // behavioural model: frame start times, W1C, completed RX frames
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_valid  <= 1'b0;
      m_over   <= 1'b0;
      m_ferr   <= 1'b0;
      m_data   <= '0;
      rx_ack   <= rx_req;
    end else begin
      cyc <= cyc + 1;
      if (bus_if.wen && bus_if.addr[3:2] == 2'd0 && !busy_at(cyc)) begin
        m_active <= 1'b1;
        m_start  <= cyc + 1;
        m_byte   <= bus_if.wdata[7:0];
      end
`ifdef UART_RX_EN
      v = m_valid; o = m_over; f = m_ferr;
      if (bus_if.wen && bus_if.addr[3:2] == 2'd1) begin
        v = v & ~bus_if.wdata[1];
        o = o & ~bus_if.wdata[2];
        f = f & ~bus_if.wdata[3];
      end
      if (rx_req != rx_ack) begin
        o = o | m_valid;
        v = 1'b1;
        f = f | ~rx_req_stop;
        m_data <= rx_req_byte;
        rx_ack <= rx_req;
      end
      m_valid <= v; m_over <= o; m_ferr <= f;
`endif
    end
  end

  // compare process
  always @(negedge clk) begin
    logic b;
    b = busy_at(cyc);
    chk("txd_line", 32'(uart_txd), 32'(exp_txd(cyc)));
    case (bus_if.addr[3:2])
      2'd0: chk("rd_txdata", bus_if.rdata, 32'd0);
      2'd1: if (rx_quiet) chk("rd_status", bus_if.rdata, {28'd0, m_ferr, m_over, m_valid, b});
            else          chk("rd_busy", 32'(bus_if.rdata[0]), 32'(b));
      2'd2: if (rx_quiet) chk("rd_rxdata", bus_if.rdata, {24'd0, m_data});
      default: chk("rd_div", bus_if.rdata, 32'(DIV));
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_if.addr  = a;
    bus_if.wdata = d;
    bus_if.wen   = 1'b1;
    tick();
    bus_if.wen   = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus_if.addr = a;
    #1;
    d = bus_if.rdata;
  endtask

  task automatic wait_idle();
    bus_if.addr = 4'h4;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (!bus_if.rdata[0]) return;
      tick();
    end
    checks++;
    failures++;
    $display("FAIL idle_timeout actual=busy required=idle t=%0t", $time);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    rx_quiet = 1'b0;
    for (int i = 0; i < 10; i++) begin
      uart_rxd = fr[i];
      repeat (DIV) tick();
    end
    uart_rxd = 1'b1;
    repeat (DIV) tick();
    rx_req_byte = b;
    rx_req_stop = stop;
    rx_req++;
    tick();
    rx_quiet = 1'b1;
  endtask

  task automatic rand_addr();
    bus_if.addr = 4'($urandom_range(0, 15));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog actual=running required=finished t=%0t", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [9:0]  cap;
    int          cnt;

    bus_if.addr  = 4'h4;
    bus_if.wen   = 1'b0;
    bus_if.wdata = '0;
    uart_rxd     = 1'b1;
    rst_n        = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // reset state
    chk("reset_txd", 32'(uart_txd), 32'd1);
    rd(4'h4, d); chk("reset_status", d, 32'h0);
    rd(4'h8, d); chk("reset_rxdata", d, 32'h0);
    rd(4'hC, d); chk("reset_div", d, 32'd8);
    tick();

    // TX frame 0xA5 with literal bit capture and busy length
    bus_write(4'h0, 32'hA5);
    bus_if.addr = 4'h4;
    cnt = 0;
    cap = '0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (!bus_if.rdata[0]) break;
      cnt++;
      if ((i % DIV) == DIV / 2 && (i / DIV) < 10) cap[i / DIV] = uart_txd;
      tick();
    end
    chk("tx_a5_bits", 32'(cap), 32'h34A);
    chk("tx_a5_busy_cycles", 32'(cnt), 32'd80);
    tick();

    // busy write discarded, then back-to-back write on the cycle busy falls
    bus_write(4'h0, 32'h96);
    repeat (20) tick();
    bus_write(4'h0, 32'h3C);
    wait_idle();
    bus_write(4'h0, 32'h3C);
    chk("b2b_start_txd", 32'(uart_txd), 32'd0);
    rd(4'h4, d); chk("b2b_busy", 32'(d[0]), 32'd1);
    wait_idle();
    tick();

    // RX + overrun, glitch, W1C, frame error
    send_rx(8'h5A, 1'b1);
    send_rx(8'h81, 1'b1);
    rd(4'h8, d); chk("rx_overrun_data", d, EXP_RX81);
    rd(4'h4, d); chk("rx_overrun_status", d, EXP_OVR_ST);
    tick();
    uart_rxd = 1'b0;
    repeat (3) tick();
    uart_rxd = 1'b1;
    repeat (3 * DIV) tick();
    rd(4'h4, d); chk("glitch_status", d, EXP_OVR_ST);
    rd(4'h8, d); chk("glitch_rxdata", d, EXP_RX81);
    tick();
    bus_write(4'h4, 32'h6);
    rd(4'h4, d); chk("w1c_status", d, 32'h0);
    tick();
    send_rx(8'h33, 1'b0);
    rd(4'h8, d); chk("ferr_rxdata", d, EXP_RX33);
    rd(4'h4, d); chk("ferr_status", d, EXP_FE_ST);
    tick();
    bus_write(4'h4, 32'hF);

    // randomized TX traffic with stray writes
    for (int n = 0; n < 6; n++) begin
      bus_write(4'h0, $urandom);
      repeat ($urandom_range(0, 95)) begin
        rand_addr();
        tick();
      end
      if ($urandom_range(0, 1) == 1) bus_write(4'h0, $urandom);
      bus_write(4'($urandom_range(2, 3) << 2), $urandom);
      rand_addr();
      tick();
      wait_idle();
      tick();
    end

    // randomized RX traffic with random W1C
    for (int n = 0; n < 5; n++) begin
      send_rx(8'($urandom), $urandom_range(0, 3) != 0);
      bus_if.addr = 4'h4; tick();
      bus_if.addr = 4'h8; tick();
      if ($urandom_range(0, 1) == 1) bus_write(4'h4, 32'($urandom_range(0, 15)));
      bus_if.addr = 4'h4; tick();
    end

    // reset in the middle of data bit 4 (a 0 for 0xA5)
    bus_write(4'h0, 32'hA5);
    repeat (5 * DIV + 3) tick();
    chk("pre_rst_bit4", 32'(uart_txd), 32'd0);
    bus_if.addr = 4'h4;
    rst_n = 1'b0;
    #1;
    chk("rst_txd", 32'(uart_txd), 32'd1);
    chk("rst_status", bus_if.rdata, 32'h0);
    repeat (5) tick();
    rst_n = 1'b1;
    tick();
    bus_write(4'h0, 32'h11);
    wait_idle();
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
